// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle around mem_bus_arbiter: fetch and data requester ports plus the
// downstream memory port. slave is the arbiter's view, master the core/memory view.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  // instruction-fetch requester
  logic              ireq_valid;
  logic [ADDR_W-1:0] ireq_addr;
  logic              iresp_addr_ok;
  logic              iresp_data_ok;
  logic [31:0]       iresp_data;

  // data-access requester
  logic              dreq_valid;
  logic [ADDR_W-1:0] dreq_addr;
  logic [2:0]        dreq_size;
  logic [7:0]        dreq_strobe;
  logic [DATA_W-1:0] dreq_data;
  logic              dresp_addr_ok;
  logic              dresp_data_ok;
  logic [DATA_W-1:0] dresp_data;

  // downstream memory port
  logic              oreq_valid;
  logic              oreq_is_write;
  logic [ADDR_W-1:0] oreq_addr;
  logic [2:0]        oreq_size;
  logic [7:0]        oreq_strobe;
  logic [DATA_W-1:0] oreq_data;
  logic              oresp_ready;
  logic              oresp_last;
  logic [DATA_W-1:0] oresp_data;

  modport slave (
    input  ireq_valid, ireq_addr,
    output iresp_addr_ok, iresp_data_ok, iresp_data,
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data,
    output oreq_valid, oreq_is_write, oreq_addr, oreq_size, oreq_strobe, oreq_data,
    input  oresp_ready, oresp_last, oresp_data
  );

  modport master (
    output ireq_valid, ireq_addr,
    input  iresp_addr_ok, iresp_data_ok, iresp_data,
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data,
    input  oreq_valid, oreq_is_write, oreq_addr, oreq_size, oreq_strobe, oreq_data,
    output oresp_ready, oresp_last, oresp_data
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one single-beat downstream memory port between the fetch and data
// requesters; one transaction in flight, ties broken round-robin.
module mem_bus_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input logic              clk,
  input logic              reset,
  mem_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic       GNT_I      = 1'b0;
  localparam logic       GNT_D      = 1'b1;
  localparam logic [2:0] FETCH_SIZE = 3'd2;

  state_t            state_reg, state_next;
  logic              last_grant_reg, last_grant_next;
  logic              owner_reg, owner_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [2:0]        size_reg, size_next;
  logic [7:0]        strobe_reg, strobe_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [31:0]       iresp_data_reg, iresp_data_next;
  logic [DATA_W-1:0] dresp_data_reg, dresp_data_next;

  logic [1:0] req_valid;
  logic [1:0] grant;
  logic [1:0] data_ok;
  logic       pick;
  logic       beat_last;

  assign req_valid[GNT_I] = bus.ireq_valid;
  assign req_valid[GNT_D] = bus.dreq_valid;
  assign beat_last        = bus.oresp_ready & bus.oresp_last;

  // A lone requester wins outright; a tie goes to whoever was not served last.
  always_comb begin
    pick = GNT_I;
    unique case (req_valid)
      2'b01:   pick = GNT_I;
      2'b10:   pick = GNT_D;
      2'b11:   pick = ~last_grant_reg;
      default: pick = GNT_I;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    owner_next      = owner_reg;
    addr_next       = addr_reg;
    size_next       = size_reg;
    strobe_next     = strobe_reg;
    wdata_next      = wdata_reg;
    iresp_data_next = iresp_data_reg;
    dresp_data_next = dresp_data_reg;
    grant           = 2'b00;

    unique case (state_reg)
      IDLE: begin
        // addr_ok is combinational, so it must stay quiet while reset is held
        if (!reset && (req_valid != 2'b00)) begin
          grant[pick]     = 1'b1;
          owner_next      = pick;
          last_grant_next = pick;
          state_next      = BUSY;
          if (pick == GNT_D) begin
            addr_next   = bus.dreq_addr;
            size_next   = bus.dreq_size;
            strobe_next = bus.dreq_strobe;
            wdata_next  = bus.dreq_data;
          end else begin
            addr_next   = bus.ireq_addr;
            size_next   = FETCH_SIZE;
            strobe_next = 8'h00;
            wdata_next  = '0;
          end
        end
      end

      BUSY: begin
        // Non-final beats are dropped; only the final beat completes the request.
        if (beat_last) begin
          state_next = RESP;
          if (owner_reg == GNT_D) begin
            dresp_data_next = bus.oresp_data;
          end else begin
            iresp_data_next = addr_reg[2] ? bus.oresp_data[63:32] : bus.oresp_data[31:0];
          end
        end
      end

      RESP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= GNT_I;
      owner_reg      <= GNT_I;
      addr_reg       <= '0;
      size_reg       <= '0;
      strobe_reg     <= '0;
      wdata_reg      <= '0;
      iresp_data_reg <= '0;
      dresp_data_reg <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      owner_reg      <= owner_next;
      addr_reg       <= addr_next;
      size_reg       <= size_next;
      strobe_reg     <= strobe_next;
      wdata_reg      <= wdata_next;
      iresp_data_reg <= iresp_data_next;
      dresp_data_reg <= dresp_data_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      localparam logic REQ_ID = 1'(gi);
      assign data_ok[gi] = (state_reg == RESP) && (owner_reg == REQ_ID);
    end
  endgenerate

  assign bus.iresp_addr_ok = grant[GNT_I];
  assign bus.dresp_addr_ok = grant[GNT_D];
  assign bus.iresp_data_ok = data_ok[GNT_I];
  assign bus.dresp_data_ok = data_ok[GNT_D];
  assign bus.iresp_data    = iresp_data_reg;
  assign bus.dresp_data    = dresp_data_reg;

  // Downstream fields come only from the latched copy of the granted request.
  assign bus.oreq_valid    = (state_reg == BUSY);
  assign bus.oreq_is_write = |strobe_reg;
  assign bus.oreq_addr     = addr_reg;
  assign bus.oreq_size     = size_reg;
  assign bus.oreq_strobe   = strobe_reg;
  assign bus.oreq_data     = wdata_reg;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expected transactions are queued in
// predicted grant order and retired against the data_ok pulses.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_d;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          exp_cyc;
  } txn_t;

  txn_t exp_q[$];
  txn_t iq[$];
  txn_t dq[$];

  int n_checks    = 0;
  int n_errors    = 0;
  int wait_states = 0;
  bit nonlast     = 1'b0;

  task automatic check(string tag, logic [255:0] act, logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic txn_t mk(logic is_d, logic [63:0] addr, logic [2:0] size,
                              logic [7:0] strobe, logic [63:0] wdata,
                              logic [63:0] rdata, int exp_cyc);
    txn_t t;
    t.is_d    = is_d;
    t.addr    = addr;
    t.size    = size;
    t.strobe  = strobe;
    t.wdata   = wdata;
    t.rdata   = rdata;
    t.exp_cyc = exp_cyc;
    return t;
  endfunction

  function automatic logic [255:0] outs();
    return 256'({bus.iresp_addr_ok, bus.iresp_data_ok, bus.iresp_data,
                 bus.dresp_addr_ok, bus.dresp_data_ok, bus.dresp_data,
                 bus.oreq_valid, bus.oreq_is_write, bus.oreq_addr,
                 bus.oreq_size, bus.oreq_strobe, bus.oreq_data});
  endfunction

  task automatic drive_req(txn_t t);
    if (t.is_d) begin
      bus.dreq_addr   = t.addr;
      bus.dreq_size   = t.size;
      bus.dreq_strobe = t.strobe;
      bus.dreq_data   = t.wdata;
      bus.dreq_valid  = 1'b1;
    end else begin
      bus.ireq_addr  = t.addr;
      bus.ireq_valid = 1'b1;
    end
  endtask

  // Queue the expectation and hand the request to its requester.
  task automatic issue(txn_t t);
    exp_q.push_back(t);
    if (t.is_d) begin
      dq.push_back(t);
      if (dq.size() == 1) drive_req(t);
    end else begin
      iq.push_back(t);
      if (iq.size() == 1) drive_req(t);
    end
  endtask

  task automatic flush();
    exp_q.delete();
    iq.delete();
    dq.delete();
    bus.ireq_valid = 1'b0;
    bus.dreq_valid = 1'b0;
  endtask

  task automatic wait_done(int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("timeout", 256'(exp_q.size()), 256'(0));
      flush();
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor, memory responder and requester agent, sampled mid-low-phase.
  initial begin
    int   busy_cnt  = 0;
    bit   beat_sent = 1'b0;
    txn_t e;
    bus.oresp_ready = 1'b0;
    bus.oresp_last  = 1'b0;
    bus.oresp_data  = '0;
    forever begin
      @(negedge clk);
      #3;
      if (bus.iresp_addr_ok || bus.dresp_addr_ok) begin
        if (exp_q.size() == 0)
          check("spurious_grant", 256'({bus.dresp_addr_ok, bus.iresp_addr_ok}), 256'(0));
        else
          check("grant", 256'({bus.dresp_addr_ok, bus.iresp_addr_ok}),
                256'(exp_q[0].is_d ? 2'b10 : 2'b01));
      end

      if (bus.oreq_valid) begin
        busy_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious_oreq", 256'(bus.oreq_valid), 256'(0));
          e = mk(1'b0, 64'h0, 3'd0, 8'h0, 64'h0, 64'h0, -1);
        end else begin
          e = exp_q[0];
          check("oreq",
                256'({bus.oreq_addr, bus.oreq_size, bus.oreq_strobe,
                      (e.is_d ? bus.oreq_data : 64'h0), bus.oreq_is_write}),
                256'({e.addr, e.size, e.strobe, (e.is_d ? e.wdata : 64'h0), |e.strobe}));
        end
        if (busy_cnt <= wait_states) begin
          bus.oresp_ready = 1'b0;
          bus.oresp_last  = 1'b0;
        end else if (nonlast && !beat_sent) begin
          bus.oresp_ready = 1'b1;
          bus.oresp_last  = 1'b0;
          bus.oresp_data  = 64'hAAAA;
          beat_sent       = 1'b1;
        end else begin
          bus.oresp_ready = 1'b1;
          bus.oresp_last  = 1'b1;
          bus.oresp_data  = e.rdata;
        end
      end else begin
        bus.oresp_ready = 1'b0;
        bus.oresp_last  = 1'b0;
        busy_cnt        = 0;
        beat_sent       = 1'b0;
      end

      if (bus.iresp_data_ok || bus.dresp_data_ok) begin
        if (exp_q.size() == 0) begin
          check("spurious_dok", 256'({bus.dresp_data_ok, bus.iresp_data_ok}), 256'(0));
        end else begin
          e = exp_q.pop_front();
          check("dok_who", 256'({bus.dresp_data_ok, bus.iresp_data_ok}),
                256'(e.is_d ? 2'b10 : 2'b01));
          if (e.is_d)
            check("dresp_data", 256'(bus.dresp_data), 256'(e.rdata));
          else
            check("iresp_data", 256'(bus.iresp_data),
                  256'(e.addr[2] ? e.rdata[63:32] : e.rdata[31:0]));
          if (e.exp_cyc >= 0)
            check("dok_cyc", 256'(cyc), 256'(e.exp_cyc));
          if (e.is_d) begin
            if (dq.size() > 0) dq.delete(0);
            if (dq.size() > 0) drive_req(dq[0]);
            else bus.dreq_valid = 1'b0;
          end else begin
            if (iq.size() > 0) iq.delete(0);
            if (iq.size() > 0) drive_req(iq[0]);
            else bus.ireq_valid = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int t0;
    bus.ireq_valid  = 1'b0;
    bus.ireq_addr   = '0;
    bus.dreq_valid  = 1'b0;
    bus.dreq_addr   = '0;
    bus.dreq_size   = '0;
    bus.dreq_strobe = '0;
    bus.dreq_data   = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", outs(), 256'(0));
    reset = 1'b0;
    @(negedge clk);

    // data write, single-cycle memory
    issue(mk(1'b1, 64'h8000_1000, 3'd3, 8'hFF, 64'hDEAD_BEEF_0000_0001,
             64'h0123_4567_89AB_CDEF, cyc + 2));
    wait_done(50);
    check("iresp_quiet", 256'({bus.iresp_addr_ok, bus.iresp_data_ok, bus.iresp_data}), 256'(0));

    // fetches: upper and lower word selection
    issue(mk(1'b0, 64'h8000_0004, 3'd2, 8'h00, 64'h0, 64'h1111_2222_3333_4444, cyc + 2));
    wait_done(50);
    issue(mk(1'b0, 64'h8000_0008, 3'd2, 8'h00, 64'h0, 64'hCAFE_F00D_1234_5678, cyc + 2));
    wait_done(50);

    // wait states then a non-final beat before the final one
    wait_states = 5;
    nonlast     = 1'b1;
    issue(mk(1'b1, 64'h8000_2008, 3'd2, 8'h00, 64'h0, 64'h5555, cyc + 8));
    wait_done(50);
    wait_states = 0;
    nonlast     = 1'b0;

    // fetch requester drops valid while BUSY
    wait_states = 2;
    issue(mk(1'b0, 64'h8000_0010, 3'd2, 8'h00, 64'h0, 64'h9999_8888_7777_6666, cyc + 4));
    @(negedge clk);
    bus.ireq_valid = 1'b0;
    wait_done(50);
    wait_states = 0;
    check("drop_idle", 256'({bus.oreq_valid, bus.iresp_addr_ok, bus.dresp_addr_ok}), 256'(0));

    // contention straight out of reset: D, I, D, I
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    t0 = cyc;
    issue(mk(1'b1, 64'h8000_4000, 3'd3, 8'h0F, 64'h0000_0000_A5A5_5A5A, 64'h1, t0 + 2));
    issue(mk(1'b0, 64'h8000_0100, 3'd2, 8'h00, 64'h0, 64'h2222_0000_3333_0000, t0 + 5));
    issue(mk(1'b1, 64'h8000_4001, 3'd0, 8'h00, 64'h0, 64'hFEDC_BA98_7654_3210, t0 + 8));
    issue(mk(1'b0, 64'h8000_0104, 3'd2, 8'h00, 64'h0, 64'h4444_5555_6666_7777, t0 + 11));
    wait_done(80);

    // reset while BUSY: outputs clear at once, no data_ok, tie then goes to DATA
    wait_states = 3;
    issue(mk(1'b0, 64'h8000_0020, 3'd2, 8'h00, 64'h0, 64'h1234, -1));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_busy_outs", outs(), 256'(0));
    flush();
    wait_states = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    t0 = cyc;
    issue(mk(1'b1, 64'h8000_3000, 3'd1, 8'h00, 64'h0, 64'h0BAD_CAFE_0000_FFFF, t0 + 2));
    issue(mk(1'b0, 64'h8000_0024, 3'd2, 8'h00, 64'h0, 64'h7777_8888_9999_AAAA, t0 + 5));
    wait_done(50);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end
endmodule
